// File: rtl/axis_tag_join_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_tag_join_if                                                     |
// | AXI4-Stream bundle (valid/ready, data, keep, id, last) for the join. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface axis_tag_join_if #(
  parameter int DATA_W = 512,
  parameter int ID_W   = 6
);
  localparam int KEEP_W = DATA_W / 8;

  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic [ID_W-1:0]   tid;
  logic              tlast;

  modport master (
    output tvalid,
    input  tready,
    output tdata,
    output tkeep,
    output tid,
    output tlast
  );

  modport slave (
    input  tvalid,
    output tready,
    input  tdata,
    input  tkeep,
    input  tid,
    input  tlast
  );
endinterface
`default_nettype wire

// File: rtl/axis_tag_join.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_tag_join                                                        |
// | Joins packet branch A with one tag beat per packet from branch B:    |
// | the low TAG_BYTES bytes of A's last beat are replaced by B's tdata.  |
// | Optional: AXIS_TAG_JOIN_TID_CHECK_EN builds the A/B tid comparator.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module axis_tag_join #(
  parameter int TAG_BYTES = 32,
  parameter int CNT_W     = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  axis_tag_join_if.slave     a_axis_i,
  axis_tag_join_if.slave     b_axis_i,
  axis_tag_join_if.master    out_axis_o,
  output logic [CNT_W-1:0]   pkt_count_o,
  output logic               err_tid_o,
  output logic               err_tag_nolast_o
);

  localparam int DATA_W = 512;
  localparam int KEEP_W = DATA_W / 8;
  localparam int ID_W   = 6;

  localparam logic [DATA_W-1:0] TAG_MASK = {DATA_W{1'b1}} >> (DATA_W - 8 * TAG_BYTES);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic [ID_W-1:0]   id;
    logic              last;
  } beat_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BODY = 2'd1,
    ST_TAIL = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       occ_q, occ_d;
  beat_t            slot0_q, slot0_d;
  beat_t            slot1_q, slot1_d;
  logic [CNT_W-1:0] pkt_count_q;
  logic             err_tag_nolast_q;

  logic             w_space;
  logic             w_a_ready;
  logic             w_b_ready;
  logic             w_push;
  logic             w_join;
  logic             w_pop;
  logic             w_out_valid;
  beat_t            w_a_beat;
  beat_t            w_push_beat;

  // Readies see only registered occupancy, so out_axis tready never reaches them.
  assign w_space     = rst_ni && (occ_q != 2'd2);
  assign w_out_valid = (occ_q != 2'd0);
  assign w_pop       = w_out_valid && out_axis_o.tready;
  assign w_a_beat    = {a_axis_i.tdata, a_axis_i.tkeep, a_axis_i.tid, a_axis_i.tlast};

  // -------------------------------------------------------------------
  // Join controller
  // -------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    w_a_ready = 1'b0;
    w_b_ready = 1'b0;
    w_push    = 1'b0;
    w_join    = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_BODY: begin
        if (a_axis_i.tvalid && !a_axis_i.tlast) begin
          w_a_ready = w_space;
          w_push    = w_space;
          if (w_space) begin
            state_d = ST_BODY;
          end
        end else if (a_axis_i.tvalid && b_axis_i.tvalid) begin
          w_a_ready = w_space;
          w_b_ready = w_space;
          w_push    = w_space;
          w_join    = w_space;
          if (w_space) begin
            state_d = ST_IDLE;
          end
        end else if (a_axis_i.tvalid) begin
          state_d = ST_TAIL;
        end
      end
      ST_TAIL: begin
        // A must still be presenting its last beat so the pair is consumed together.
        if (a_axis_i.tvalid && b_axis_i.tvalid && w_space) begin
          w_a_ready = 1'b1;
          w_b_ready = 1'b1;
          w_push    = 1'b1;
          w_join    = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign a_axis_i.tready = w_a_ready;
  assign b_axis_i.tready = w_b_ready;

  always_comb begin
    w_push_beat = w_a_beat;
    if (w_join) begin
      w_push_beat.data = (b_axis_i.tdata & TAG_MASK) | (a_axis_i.tdata & ~TAG_MASK);
      w_push_beat.last = 1'b1;
    end
  end

  // -------------------------------------------------------------------
  // Two-entry output skid: slot0 drives the port, slot1 absorbs a stall
  // -------------------------------------------------------------------
  always_comb begin
    occ_d   = occ_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    unique case ({w_push, w_pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          slot0_d = w_push_beat;
        end else begin
          slot1_d = w_push_beat;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        occ_d   = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          slot0_d = w_push_beat;
        end else begin
          slot0_d = slot1_q;
          slot1_d = w_push_beat;
        end
      end
      default: begin
        occ_d = occ_q;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q   <= 2'd0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      occ_q   <= occ_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  assign out_axis_o.tvalid = w_out_valid;
  assign out_axis_o.tdata  = slot0_q.data;
  assign out_axis_o.tkeep  = slot0_q.keep;
  assign out_axis_o.tid    = slot0_q.id;
  assign out_axis_o.tlast  = slot0_q.last;

  // -------------------------------------------------------------------
  // Statistics and sticky error flags
  // -------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pkt_count_q <= '0;
    end else if (w_pop && slot0_q.last) begin
      pkt_count_q <= pkt_count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_tag_nolast_q <= 1'b0;
    end else if (w_join && !b_axis_i.tlast) begin
      err_tag_nolast_q <= 1'b1;
    end
  end

  assign pkt_count_o      = pkt_count_q;
  assign err_tag_nolast_o = err_tag_nolast_q;

`ifdef AXIS_TAG_JOIN_TID_CHECK_EN
  logic err_tid_q;
  logic w_unused_b;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_tid_q <= 1'b0;
    end else if (w_join && (a_axis_i.tid != b_axis_i.tid)) begin
      err_tid_q <= 1'b1;
    end
  end

  assign err_tid_o  = err_tid_q;
  assign w_unused_b = ^b_axis_i.tkeep;
`else
  logic w_unused_b;

  assign err_tid_o  = 1'b0;
  assign w_unused_b = ^{b_axis_i.tkeep, b_axis_i.tid};
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_tag_join.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_axis_tag_join                                                     |
// | Randomized and directed bench for axis_tag_join with a queue model.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_axis_tag_join;

  localparam int TAG_BYTES = 32;
  localparam int CNT_W     = 32;
  localparam int DW        = 512;
  localparam int KW        = 64;
`ifdef AXIS_TAG_JOIN_TID_CHECK_EN
  localparam bit EXP_TID_ERR = 1'b1;
`else
  localparam bit EXP_TID_ERR = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [5:0]    id;
    logic          last;
  } beat_t;

  logic             clk_i  = 1'b0;
  logic             rst_ni = 1'b0;
  logic [CNT_W-1:0] pkt_count;
  logic             err_tid;
  logic             err_tag_nolast;

  axis_tag_join_if a_if ();
  axis_tag_join_if b_if ();
  axis_tag_join_if out_if ();

  axis_tag_join #(
    .TAG_BYTES (TAG_BYTES),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .a_axis_i         (a_if),
    .b_axis_i         (b_if),
    .out_axis_o       (out_if),
    .pkt_count_o      (pkt_count),
    .err_tid_o        (err_tid),
    .err_tag_nolast_o (err_tag_nolast)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int    n_checks = 0;
  int    n_pass   = 0;
  beat_t a_q[$];
  beat_t b_q[$];
  beat_t e_q[$];
  int    a_gap[$];
  int    b_gap[$];
  int    out_cyc[$];
  int    stall;
  int    max_occ;
  int    b_hs_cyc;
  int    pkt_exp;
  bit    done;

  task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference model: packet beats pass through; the last beat takes the tag's low bytes.
  task automatic add_pkt(input int len, input logic [5:0] aid, input logic [5:0] bid,
                         input logic blast, input int agmax, input int bgap, input bit aa);
    beat_t tg;
    beat_t bt;
    beat_t ex;
    tg.data = aa ? {64{8'hAA}} : rnd_data();
    tg.keep = '1;
    tg.id   = bid;
    tg.last = blast;
    b_q.push_back(tg);
    b_gap.push_back(bgap);
    for (int i = 0; i < len; i++) begin
      bt.data = rnd_data();
      bt.keep = {$urandom, $urandom};
      bt.id   = aid;
      bt.last = (i == len - 1);
      a_q.push_back(bt);
      a_gap.push_back(int'($urandom_range(0, agmax)));
      ex = bt;
      if (bt.last)
        for (int k = 0; k < TAG_BYTES; k++) ex.data[8*k +: 8] = tg.data[8*k +: 8];
      e_q.push_back(ex);
    end
  endtask

  task automatic send_a(input beat_t bt);
    bit took = 0;
    int n    = 0;
    a_if.tvalid = 1'b1;
    a_if.tdata  = bt.data;
    a_if.tkeep  = bt.keep;
    a_if.tid    = bt.id;
    a_if.tlast  = bt.last;
    while (!took && n < 2000) begin
      @(negedge clk_i);
      took = a_if.tready;
      n++;
      tick();
    end
    a_if.tvalid = 1'b0;
    check_val("a_handshake", took, 1);
  endtask

  task automatic send_b(input beat_t bt);
    bit took = 0;
    int n    = 0;
    b_if.tvalid = 1'b1;
    b_if.tdata  = bt.data;
    b_if.tid    = bt.id;
    b_if.tlast  = bt.last;
    while (!took && n < 2000) begin
      @(negedge clk_i);
      took = b_if.tready;
      if (took) b_hs_cyc = cyc;
      n++;
      tick();
    end
    b_if.tvalid = 1'b0;
    check_val("b_handshake", took, 1);
  endtask

  // mode: 0 random out ready, 1 always ready, 2 alternating ready
  task automatic run_traffic(input int mode, input int budget);
    tick();
    done = 0;
    out_cyc.delete();
    stall   = 0;
    max_occ = 0;
    fork
      begin
        while (a_q.size() > 0) begin
          beat_t bt;
          int    g;
          bt = a_q.pop_front();
          g  = a_gap.pop_front();
          repeat (g) tick();
          send_a(bt);
        end
      end
      begin
        while (b_q.size() > 0) begin
          beat_t bt;
          int    g;
          bt = b_q.pop_front();
          g  = b_gap.pop_front();
          repeat (g) tick();
          send_b(bt);
        end
      end
      begin
        while (!done) begin
          case (mode)
            0:       out_if.tready = ($urandom_range(0, 3) != 0);
            1:       out_if.tready = 1'b1;
            default: out_if.tready = ~out_if.tready;
          endcase
          tick();
        end
        out_if.tready = 1'b1;
      end
      begin
        int            waited = 0;
        int            occ    = 0;
        bit            hold_v = 0;
        logic [DW-1:0] hold_d = '0;
        beat_t         ex;
        while (e_q.size() > 0 && waited < budget) begin
          @(negedge clk_i);
          waited++;
          if (hold_v) begin
            check_val("hold_valid", out_if.tvalid, 1);
            check_val("hold_data", out_if.tdata, hold_d);
          end
          hold_v = out_if.tvalid && !out_if.tready;
          hold_d = out_if.tdata;
          if (a_if.tvalid && a_if.tlast && !a_if.tready) stall++;
          if (b_if.tready)
            check_val("b_ready_only_at_join",
                      a_if.tvalid && a_if.tlast && a_if.tready && b_if.tvalid, 1);
          if (a_if.tvalid && a_if.tready) occ++;
          if (out_if.tvalid && out_if.tready) begin
            ex = e_q.pop_front();
            check_val("out_data", out_if.tdata, ex.data);
            check_val("out_ctl", {out_if.tkeep, out_if.tid, out_if.tlast},
                      {ex.keep, ex.id, ex.last});
            out_cyc.push_back(cyc);
            occ--;
          end
          if (occ > max_occ) max_occ = occ;
        end
        check_val("all_beats_out", e_q.size(), 0);
        e_q.delete();
        done = 1;
      end
    join
    tick();
    tick();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    a_if.tvalid   = 1'b1;
    a_if.tdata    = rnd_data();
    a_if.tkeep    = '1;
    a_if.tid      = 6'd1;
    a_if.tlast    = 1'b0;
    b_if.tvalid   = 1'b1;
    b_if.tdata    = rnd_data();
    b_if.tkeep    = '1;
    b_if.tid      = 6'd1;
    b_if.tlast    = 1'b1;
    out_if.tready = 1'b1;
    pkt_exp       = 0;

    // Reset state, with inputs trying to transfer
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_val("rst_a_ready", a_if.tready, 0);
    check_val("rst_b_ready", b_if.tready, 0);
    check_val("rst_out_valid", out_if.tvalid, 0);
    check_val("rst_out_data", out_if.tdata, 0);
    check_val("rst_out_ctl", {out_if.tkeep, out_if.tid, out_if.tlast}, 0);
    check_val("rst_pkt_count", pkt_count, 0);
    check_val("rst_flags", {err_tid, err_tag_nolast}, 0);
    a_if.tvalid = 1'b0;
    b_if.tvalid = 1'b0;
    tick();
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_val("post_rst_out_valid", out_if.tvalid, 0);

    // 3-beat packet, early all-0xAA tag
    add_pkt(3, 6'd5, 6'd5, 1'b1, 0, 0, 1'b1);
    run_traffic(1, 200);
    pkt_exp += 1;
    check_val("d1_beats", out_cyc.size(), 3);
    check_val("d1_consecutive", (out_cyc.size() == 3) ? out_cyc[2] - out_cyc[0] : -1, 2);
    check_val("d1_pkt_count", pkt_count, pkt_exp);

    // Tag arrives 10 cycles after A's last beat is presented
    add_pkt(3, 6'd5, 6'd5, 1'b1, 0, 12, 1'b0);
    run_traffic(1, 200);
    pkt_exp += 1;
    check_val("d2_tail_stall", stall, 10);
    check_val("d2_join_latency", (out_cyc.size() == 3) ? out_cyc[2] - b_hs_cyc : -1, 1);
    check_val("d2_pkt_count", pkt_count, pkt_exp);

    // Four back-to-back single-beat packets
    for (int i = 0; i < 4; i++) add_pkt(1, 6'(i + 10), 6'(i + 10), 1'b1, 0, 0, 1'b0);
    run_traffic(1, 200);
    pkt_exp += 4;
    check_val("d3_consecutive", (out_cyc.size() == 4) ? out_cyc[3] - out_cyc[0] : -1, 3);
    check_val("d3_pkt_count", pkt_count, pkt_exp);

    // 5-beat packet with alternating out ready
    add_pkt(5, 6'd1, 6'd1, 1'b1, 0, 0, 1'b0);
    run_traffic(2, 200);
    pkt_exp += 1;
    check_val("d4_occupancy_le2", max_occ <= 2, 1);
    check_val("d4_pkt_count", pkt_count, pkt_exp);

    // Randomized packets, gaps and backpressure
    for (int p = 0; p < 30; p++) begin
      logic [5:0] id;
      id = 6'($urandom_range(0, 63));
      add_pkt(int'($urandom_range(1, 5)), id, id, 1'b1, 2, int'($urandom_range(0, 8)), 1'b0);
    end
    run_traffic(0, 20000);
    pkt_exp += 30;
    check_val("rand_occupancy_le2", max_occ <= 2, 1);
    check_val("rand_pkt_count", pkt_count, pkt_exp);
    check_val("rand_flags", {err_tid, err_tag_nolast}, 0);

    // Tag with tlast=0 is still used, flag is sticky
    add_pkt(2, 6'd7, 6'd7, 1'b0, 0, 0, 1'b0);
    run_traffic(1, 200);
    pkt_exp += 1;
    check_val("nolast_flag", err_tag_nolast, 1);
    check_val("nolast_tid_flag", err_tid, 0);

    // tid mismatch
    add_pkt(1, 6'd3, 6'd4, 1'b1, 0, 0, 1'b0);
    run_traffic(1, 200);
    pkt_exp += 1;
    check_val("tid_mismatch_flag", err_tid, EXP_TID_ERR);
    add_pkt(1, 6'd9, 6'd9, 1'b1, 0, 0, 1'b0);
    run_traffic(1, 200);
    pkt_exp += 1;
    check_val("tid_flag_sticky", err_tid, EXP_TID_ERR);
    check_val("pre_rst_pkt_count", pkt_count, pkt_exp);

    // Reset in the middle of a 4-beat packet, with two beats buffered
    out_if.tready = 1'b0;
    begin
      beat_t bt;
      for (int i = 0; i < 2; i++) begin
        bt.data = rnd_data();
        bt.keep = '1;
        bt.id   = 6'd2;
        bt.last = 1'b0;
        send_a(bt);
      end
    end
    @(negedge clk_i);
    check_val("pre_rst_out_valid", out_if.tvalid, 1);
    a_if.tvalid = 1'b1;
    a_if.tlast  = 1'b0;
    rst_ni      = 1'b0;
    #1;
    check_val("mid_rst_out_valid", out_if.tvalid, 0);
    check_val("mid_rst_out_data", out_if.tdata, 0);
    check_val("mid_rst_out_ctl", {out_if.tkeep, out_if.tid, out_if.tlast}, 0);
    check_val("mid_rst_pkt_count", pkt_count, 0);
    check_val("mid_rst_flags", {err_tid, err_tag_nolast}, 0);
    check_val("mid_rst_a_ready", a_if.tready, 0);
    a_if.tvalid = 1'b0;
    tick();
    rst_ni        = 1'b1;
    out_if.tready = 1'b1;
    pkt_exp       = 0;
    add_pkt(2, 6'd6, 6'd6, 1'b1, 0, 0, 1'b0);
    run_traffic(1, 200);
    pkt_exp += 1;
    check_val("after_rst_pkt_count", pkt_count, pkt_exp);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_tag_join.md
# axis_tag_join

Rejoins the two branches of a duplicated 512-bit AXI4-Stream in the HMAC-verify path. Input A carries the original packet beats; input B carries exactly one tag beat per packet, e.g. a computed HMAC. The block forwards A unchanged except on A's last beat, where the low TAG_BYTES bytes of tdata are replaced by B's tag. It waits for the tag when needed, keeps the packet/tag pairing in order, and drives a registered output with full throughput.

## Interface
- TAG_BYTES, 32: number of low-order bytes of A's last beat replaced by B's tdata; legal range 1..64.
- CNT_W, 32: width of the statistics counters.

- clock  in  1  sole clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- a_axis_tvalid / a_axis_tready  in / out  1 / 1  packet-branch handshake.
- a_axis_tdata / a_axis_tkeep / a_axis_tid / a_axis_tlast  in  512 / 64 / 6 / 1  packet beat.
- b_axis_tvalid / b_axis_tready  in / out  1 / 1  tag-branch handshake.
- b_axis_tdata / b_axis_tid / b_axis_tlast  in  512 / 6 / 1  tag beat; tlast must be 1.
- out_axis_tvalid / out_axis_tready  out / in  1 / 1  output handshake.
- out_axis_tdata / out_axis_tkeep / out_axis_tid / out_axis_tlast  out  512 / 64 / 6 / 1  joined beat.
- pkt_count  out  CNT_W  number of packets completed on the output side.
- err_tid  out  1  sticky flag: A's tid differed from B's tid at a join.
- err_tag_nolast  out  1  sticky flag: a B beat was consumed with tlast=0.

## Operation
- FSM states:
  - IDLE: at a packet boundary.
  - BODY: inside a packet, non-last beats flowing.
  - TAIL: A's last beat is pending and its tag is not yet valid.
- Non-last A beat (IDLE or BODY): a_axis_tready = space available in the output stage. The beat is copied to the output unchanged. IDLE→BODY on the first such beat.
- Last A beat in IDLE or BODY:
  - With b_axis_tvalid=1: A and B are consumed in the same cycle and the FSM returns to IDLE.
  - With b_axis_tvalid=0: the FSM moves to TAIL and a_axis_tready=0.
- TAIL: both tready signals assert together in the cycle where B is valid and the output stage has space. Both beats are consumed and the FSM moves to IDLE.
- Joined beat:
  - tdata[8*TAG_BYTES-1:0] comes from B; the remaining bytes come from A.
  - tkeep, tid and tlast (=1) come from A.
- A single-beat packet (IDLE with tlast=1) takes the join path directly.
- b_axis_tready is 0 at every point except a join. B beats are never dropped or reordered.
- err_tag_nolast is set when a B beat is consumed with tlast=0. The beat is still used as the tag.
- pkt_count increments when an output beat with tlast=1 handshakes. It wraps modulo 2^CNT_W.
- Reset, including mid-packet: the FSM goes to IDLE, the output stage empties, counters and flags clear, and any partial packet is discarded.

## Timing
- Values during and immediately after reset:
  - out_axis_tvalid=0, out_axis_tdata/tkeep/tid/tlast=0.
  - a_axis_tready=0 and b_axis_tready=0 while reset is low.
  - pkt_count=0, err_tid=0, err_tag_nolast=0.
- Output stage is a 2-entry skid buffer. Latency is one cycle from input handshake to out_axis_tvalid.
- Throughput is 1 beat/cycle while out_axis_tready=1 and B tags arrive no later than A's last beat.
- Input readies depend only on registered state and the skid occupancy, never combinationally on out_axis_tready.
- out_axis_tvalid, once asserted, holds with stable data until the output handshake completes.
- A tag arriving early, while A is in BODY, is held by the upstream FIFO and consumed only at the join.
- If out_axis_tready drops on the join cycle, the join proceeds only when the skid has space. A and B remain paired.

## Configuration
- AXIS_TAG_JOIN_TID_CHECK_EN defined:
  - At each join, A's tid is compared with B's tid. A mismatch sets err_tid.
  - The output beat is still emitted. Flow control is unaffected.
- Macro undefined: no comparator is built and err_tid is tied to 0.

## Test plan
- 3-beat packet on A with tid=5; tag beat on B with tid=5 and tdata=all-0xAA, available before A's last beat; TAG_BYTES=32 → 3 output beats on consecutive cycles. Beat 3 has bytes 0..31 = 0xAA, bytes 32..63 = A's bytes, tlast=1. pkt_count=1.
- Same 3-beat packet, but the B tag arrives 10 cycles after A's last beat is presented → FSM in TAIL. a_axis_tready=0 for those 10 cycles. The joined beat appears 1 cycle after the B handshake.
- Four back-to-back 1-beat packets, B always valid, out_axis_tready=1 → 4 output beats in 4 consecutive cycles. pkt_count=4.
- out_axis_tready toggling 1,0,1,0 during a 5-beat packet → no beat lost or duplicated, output data stable while stalled, and at most 2 beats buffered.
- With the macro defined: A tid=3, B tid=4 → joined beat emitted and err_tid=1 until reset. With the macro undefined, the same stimulus leaves err_tid=0.
- Reset asserted after beat 2 of a 4-beat packet → all outputs return to their reset values at once. A fresh 2-beat packet with a tag afterwards joins correctly and pkt_count=1.
